// File: rtl/crypto_test_onchip_mem_pipe.sv
// Single-port on-chip RAM behind an Avalon-MM slave with 1/2-cycle pipelined reads and sticky out-of-range flag.
// Optional post-reset scrub engine enabled by defining CRYPTO_TEST_MEM_SCRUB_EN.
module crypto_test_onchip_mem_pipe #(
  parameter int                DATA_W       = 32,
  parameter int                DEPTH        = 4096,
  parameter int                ADDR_W       = 12,
  parameter int                READ_LATENCY = 1,
  parameter string             INIT_FILE    = "",
  parameter logic [DATA_W-1:0] INIT_WORD    = {DATA_W{1'b0}}
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [ADDR_W-1:0]    address,
  input  logic [DATA_W/8-1:0]  byteenable,
  input  logic                 chipselect,
  input  logic                 read,
  input  logic                 write,
  input  logic [DATA_W-1:0]    writedata,
  input  logic                 clken,
  input  logic                 reset_req,
  output logic                 waitrequest,
  output logic [DATA_W-1:0]    readdata,
  output logic                 readdatavalid,
  output logic                 oob_err,
  output logic                 scrub_done
);

  localparam int                BE_W      = DATA_W / 8;
  localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  generate
    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
      $error("crypto_test_onchip_mem_pipe: READ_LATENCY must be 1 or 2");
    end
    if ((DATA_W % 8) != 0) begin : g_bad_width
      $error("crypto_test_onchip_mem_pipe: DATA_W must be a multiple of 8");
    end
  endgenerate

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_stall;
  logic              w_accept;
  logic              w_wr_acc;
  logic              w_rd_acc;
  logic              w_oob;
  logic [DATA_W-1:0] w_rd_word;

  assign w_stall     = ~clken | reset_req | ~scrub_done;
  assign waitrequest = w_stall;
  assign w_accept    = chipselect & (read | write) & ~w_stall;
  assign w_wr_acc    = w_accept & write;
  // A simultaneous read+write is treated as a write only.
  assign w_rd_acc    = w_accept & read & ~write;
  assign w_oob       = ({1'b0, address} >= DEPTH_X);

  // Read word selection; out-of-range reads return zero.
  always_comb begin
    w_rd_word = {DATA_W{1'b0}};
    if (w_oob) begin
      w_rd_word = {DATA_W{1'b0}};
    end else begin
      w_rd_word = r_mem[address];
    end
  end

`ifdef CRYPTO_TEST_MEM_SCRUB_EN
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCRUB = 2'd1,
    S_READY = 2'd2
  } scrub_state_t;

  scrub_state_t      r_state;
  logic [ADDR_W-1:0] r_scrub_addr;
  logic              w_scrub_we;

  assign w_scrub_we = (r_state == S_SCRUB) & clken & ~reset_req;

  // Scrub FSM: sweep every word once, then open the port to traffic.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_scrub_addr <= {ADDR_W{1'b0}};
      scrub_done   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state <= S_SCRUB;
        end
        S_SCRUB: begin
          if (w_scrub_we) begin
            if (r_scrub_addr == LAST_ADDR) begin
              r_state    <= S_READY;
              scrub_done <= 1'b1;
            end else begin
              r_scrub_addr <= r_scrub_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
            end
          end
        end
        S_READY: begin
          scrub_done <= 1'b1;
        end
        default: begin
          r_state    <= S_IDLE;
          scrub_done <= 1'b0;
        end
      endcase
    end
  end

  // Memory write port shared between the scrub engine and bus writes.
  always_ff @(posedge clk) begin
    if (w_scrub_we) begin
      r_mem[r_scrub_addr] <= INIT_WORD;
    end else if (w_wr_acc && !w_oob) begin
      for (int i = 0; i < BE_W; i++) begin
        if (byteenable[i]) begin
          r_mem[address][8*i +: 8] <= writedata[8*i +: 8];
        end
      end
    end
  end
`else
  // Without scrubbing the port is ready from the first edge after reset release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scrub_done <= 1'b0;
    end else begin
      scrub_done <= 1'b1;
    end
  end

  // Byte-lane bus writes; out-of-range writes are dropped.
  always_ff @(posedge clk) begin
    if (w_wr_acc && !w_oob) begin
      for (int i = 0; i < BE_W; i++) begin
        if (byteenable[i]) begin
          r_mem[address][8*i +: 8] <= writedata[8*i +: 8];
        end
      end
    end
  end
`endif

  // Sticky out-of-range flag, cleared only by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      oob_err <= 1'b0;
    end else if (w_accept && w_oob) begin
      oob_err <= 1'b1;
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic              r_v1;
      logic [DATA_W-1:0] r_d1;

      // Two-stage read pipe; a stall freezes stage 1 and suppresses the output pulse.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_v1          <= 1'b0;
          r_d1          <= {DATA_W{1'b0}};
          readdatavalid <= 1'b0;
          readdata      <= {DATA_W{1'b0}};
        end else if (w_stall) begin
          readdatavalid <= 1'b0;
        end else begin
          r_v1          <= w_rd_acc;
          readdatavalid <= r_v1;
          if (w_rd_acc) begin
            r_d1 <= w_rd_word;
          end
          if (r_v1) begin
            readdata <= r_d1;
          end
        end
      end
    end else begin : g_lat1
      // Single-stage read: data registered at the accepting edge, readdata holds otherwise.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          readdatavalid <= 1'b0;
          readdata      <= {DATA_W{1'b0}};
        end else begin
          readdatavalid <= w_rd_acc;
          if (w_rd_acc) begin
            readdata <= w_rd_word;
          end
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_crypto_test_onchip_mem_pipe.sv
// Bench for crypto_test_onchip_mem_pipe: one latency-1 and one latency-2 instance share stimulus and a
// behavioural memory/read-queue model. Honours CRYPTO_TEST_MEM_SCRUB_EN when defined.
module tb_crypto_test_onchip_mem_pipe;

  localparam int          DW    = 32;
  localparam int          AW    = 12;
  localparam int          DEPTH = 3000;
  localparam logic [31:0] IW    = 32'hA5A5A5A5;
`ifdef CRYPTO_TEST_MEM_SCRUB_EN
  localparam int READY_EDGES = DEPTH + 1;
`else
  localparam int READY_EDGES = 1;
`endif

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [AW-1:0] address = '0;
  logic [3:0]    byteenable = '0;
  logic          chipselect = 1'b0, read = 1'b0, write = 1'b0;
  logic [DW-1:0] writedata = '0;
  logic          clken = 1'b1, reset_req = 1'b0;

  logic          wr_a[2], rdv_a[2], oob_a[2], sd_a[2];
  logic [DW-1:0] rd_a[2];

  always #5 clk = ~clk;

  crypto_test_onchip_mem_pipe #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .READ_LATENCY(1),
                                .INIT_FILE(""), .INIT_WORD(IW)) u_l1 (
    .clk(clk), .reset_n(reset_n), .address(address), .byteenable(byteenable),
    .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
    .clken(clken), .reset_req(reset_req), .waitrequest(wr_a[0]), .readdata(rd_a[0]),
    .readdatavalid(rdv_a[0]), .oob_err(oob_a[0]), .scrub_done(sd_a[0]));

  crypto_test_onchip_mem_pipe #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .READ_LATENCY(2),
                                .INIT_FILE(""), .INIT_WORD(IW)) u_l2 (
    .clk(clk), .reset_n(reset_n), .address(address), .byteenable(byteenable),
    .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
    .clken(clken), .reset_req(reset_req), .waitrequest(wr_a[1]), .readdata(rd_a[1]),
    .readdatavalid(rdv_a[1]), .oob_err(oob_a[1]), .scrub_done(sd_a[1]));

  typedef struct {
    logic [31:0] d;
    bit          known;
    int          rem;
  } ent_t;

  logic [31:0] mem_m [DEPTH];
  bit          known_m [DEPTH];
  ent_t        qq [2][$];
  logic [31:0] last_m [2];
  bit          ready_m, oob_m;
  int          edges_m;
  int          n_cmp = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset_n = 1'b0; chipselect = 1'b0; read = 1'b0; write = 1'b0; clken = 1'b1; reset_req = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_rdv_l%0d", k+1), {31'd0, rdv_a[k]}, 32'd0);
      chk($sformatf("rst_rdata_l%0d", k+1), rd_a[k], 32'd0);
      chk($sformatf("rst_oob_l%0d", k+1), {31'd0, oob_a[k]}, 32'd0);
      chk($sformatf("rst_wait_l%0d", k+1), {31'd0, wr_a[k]}, 32'd1);
      chk($sformatf("rst_sdone_l%0d", k+1), {31'd0, sd_a[k]}, 32'd0);
      qq[k].delete();
      last_m[k] = 32'd0;
    end
    oob_m = 1'b0; ready_m = 1'b0; edges_m = 0;
`ifdef CRYPTO_TEST_MEM_SCRUB_EN
    for (int i = 0; i < DEPTH; i++) begin
      mem_m[i] = IW; known_m[i] = 1'b1;
    end
`endif
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  // One bus cycle: drive, sample mid-cycle against the model, then advance the model at the edge.
  task automatic cycle(input logic cs, input logic rd, input logic wr, input logic [AW-1:0] a,
                       input logic [3:0] be, input logic [31:0] wd, input logic ce, input logic rr);
    logic exp_wait, acc, is_oob, exp_v;
    ent_t e;
    chipselect = cs; read = rd; write = wr; address = a; byteenable = be; writedata = wd;
    clken = ce; reset_req = rr;
    @(negedge clk);
    exp_wait = !ce || rr || !ready_m;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("wait_l%0d", k+1), {31'd0, wr_a[k]}, {31'd0, exp_wait});
      chk($sformatf("sdone_l%0d", k+1), {31'd0, sd_a[k]}, {31'd0, ready_m});
      chk($sformatf("oob_l%0d", k+1), {31'd0, oob_a[k]}, {31'd0, oob_m});
      exp_v = (qq[k].size() > 0) && (qq[k][0].rem == 0);
      chk($sformatf("rdv_l%0d", k+1), {31'd0, rdv_a[k]}, {31'd0, exp_v});
      if (exp_v) begin
        if (qq[k][0].known) begin
          chk($sformatf("rdata_l%0d", k+1), rd_a[k], qq[k][0].d);
        end
        last_m[k] = qq[k][0].known ? qq[k][0].d : 32'hxxxxxxxx;
        void'(qq[k].pop_front());
      end else if (!$isunknown(last_m[k])) begin
        chk($sformatf("hold_l%0d", k+1), rd_a[k], last_m[k]);
      end
    end
    acc = cs && (rd || wr) && !exp_wait;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < qq[k].size(); i++) begin
        if (!exp_wait && qq[k][i].rem > 0) qq[k][i].rem = qq[k][i].rem - 1;
      end
    end
    if (acc) begin
      is_oob = (int'(a) >= DEPTH);
      if (is_oob) oob_m = 1'b1;
      if (wr) begin
        if (!is_oob) begin
          for (int b = 0; b < 4; b++) begin
            if (be[b]) mem_m[a][8*b +: 8] = wd[8*b +: 8];
          end
          if (be == 4'hF) known_m[a] = 1'b1;
        end
      end else begin
        e.d = is_oob ? 32'd0 : mem_m[a];
        e.known = is_oob || known_m[a];
        e.rem = 0; qq[0].push_back(e);
        e.rem = 1; qq[1].push_back(e);
      end
    end
    if (!ready_m) begin
      edges_m++;
      if (edges_m >= READY_EDGES) ready_m = 1'b1;
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 12'd0, 4'h0, 32'd0, 1'b1, 1'b0);
  endtask

  task automatic wait_ready();
    for (int i = 0; i < READY_EDGES + 4 && !ready_m; i++) idle(1);
  endtask

  initial begin
    logic [AW-1:0] ra;
    int op;
    for (int i = 0; i < DEPTH; i++) begin
      mem_m[i] = 32'd0; known_m[i] = 1'b0;
    end
    @(posedge clk); #1;
    apply_reset();
`ifdef CRYPTO_TEST_MEM_SCRUB_EN
    idle(10);
    apply_reset();
`endif
    wait_ready();
    idle(2);

    // Byte-lane merge and byteenable=0 no-op
    cycle(1, 0, 1, 12'h010, 4'hF, 32'hDEADBEEF, 1, 0);
    cycle(1, 0, 1, 12'h010, 4'h1, 32'h000000AA, 1, 0);
    cycle(1, 1, 0, 12'h010, 4'h0, 32'd0, 1, 0);
    idle(3);
    cycle(1, 0, 1, 12'h010, 4'h0, 32'hFFFFFFFF, 1, 0);
    cycle(1, 1, 0, 12'h010, 4'h0, 32'd0, 1, 0);
    // Read+write together: write only
    cycle(1, 1, 1, 12'h020, 4'hF, 32'h12345678, 1, 0);
    cycle(1, 1, 0, 12'h020, 4'h0, 32'd0, 1, 0);
    idle(3);

    for (int i = 0; i < 64; i++) cycle(1, 0, 1, AW'(i), 4'hF, $urandom, 1, 0);
    // Burst with clken and reset_req stalls mid-flight
    cycle(1, 1, 0, 12'd0, 4'h0, 32'd0, 1, 0);
    cycle(1, 1, 0, 12'd1, 4'h0, 32'd0, 1, 0);
    cycle(1, 1, 0, 12'd2, 4'h0, 32'd0, 0, 0);
    cycle(1, 1, 0, 12'd2, 4'h0, 32'd0, 1, 0);
    cycle(1, 1, 0, 12'd3, 4'h0, 32'd0, 1, 0);
    cycle(1, 1, 0, 12'd4, 4'h0, 32'd0, 1, 1);
    cycle(1, 1, 0, 12'd4, 4'h0, 32'd0, 1, 0);
    idle(3);

    // Out-of-range boundary
    cycle(1, 0, 1, 12'd2999, 4'hF, 32'hCAFEF00D, 1, 0);
    cycle(1, 0, 1, 12'd3000, 4'hF, 32'h0BADF00D, 1, 0);
    cycle(1, 1, 0, 12'd3000, 4'h0, 32'd0, 1, 0);
    cycle(1, 1, 0, 12'd2999, 4'h0, 32'd0, 1, 0);
    cycle(1, 1, 0, 12'd4095, 4'h0, 32'd0, 1, 0);
    idle(4);

    for (int n = 0; n < 400; n++) begin
      op = $urandom_range(0, 3);
      if ($urandom_range(0, 31) == 0) ra = AW'($urandom_range(3000, 4095));
      else if ($urandom_range(0, 15) == 0) ra = AW'($urandom_range(2990, 2999));
      else ra = AW'($urandom_range(0, 63));
      cycle($urandom_range(0, 7) != 0, op[0], op[1], ra, 4'($urandom), $urandom,
            $urandom_range(0, 9) != 0, $urandom_range(0, 19) == 0);
    end
    idle(4);

    // Reset with reads in flight: results discarded, oob cleared
    cycle(1, 1, 0, 12'h010, 4'h0, 32'd0, 1, 0);
    apply_reset();
    wait_ready();
    cycle(1, 1, 0, 12'h020, 4'h0, 32'd0, 1, 0);
    cycle(1, 1, 0, 12'd2999, 4'h0, 32'd0, 1, 0);
    idle(4);
    for (int k = 0; k < 2; k++) chk($sformatf("drain_l%0d", k+1), qq[k].size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
